// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: eight-line interrupt pending/mask block with a
// request / acknowledge / end-of-interrupt handshake towards the servicing
// logic. The masked pending vector feeds an external 8:3 priority encoder
// whose output comes back on idx_in.
//
// Optional feature macro: IRQ_EDGE_DETECT_EN
//   defined   - a line event is a 0->1 transition of the sampled request
//               line; a repeat event on an already pending line sets ovf.
//   undefined - a line event is the sampled request line being high in any
//               cycle (level mode); ovf never sets.
module irq_pending_ctrl #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  irq_in,
  input  logic          mask_we,
  input  logic [N-1:0]  mask_wdata,
  output logic [N-1:0]  pend,
  input  logic [IW-1:0] idx_in,
  output logic          irq_req,
  input  logic          irq_ack,
  input  logic          irq_eoi,
  output logic [IW-1:0] cur_idx,
  output logic          busy,
  output logic          ovf,
  input  logic          ovf_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [N-1:0] irq_s;     // registered copy of the raw request lines
  logic [N-1:0] pending;   // captured events, independent of the mask
  logic [N-1:0] mask;      // 1 = line visible on pend
  logic [N-1:0] evt;       // line events seen this cycle
  logic [N-1:0] clr_vec;   // one-hot clear of the acknowledged line
  logic         ovf_set;
  logic         ack_take;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N-1:0] irq_prev;

  // Edge history: previous-cycle sample of the request lines. It loads the
  // live inputs during reset so a line already high when reset releases is
  // not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) irq_prev <= irq_in;
    else     irq_prev <= irq_s;
  end

  assign evt     = irq_s & ~irq_prev;
  assign ovf_set = |(evt & pending);
`else
  assign evt     = irq_s;
  assign ovf_set = 1'b0;
`endif

  // The encoder only sees unmasked lines; masked ones stay latched in pending.
  assign pend = pending & mask;

  // An ack counts only in REQ and only if the encoder points at a line that
  // is really pending, so an ack racing a mask write to zero is dropped.
  assign ack_take = (state == REQ) && irq_ack && pend[idx_in];
  assign clr_vec  = ack_take ? (N'(1) << idx_in) : '0;

  // Datapath registers: input sample, pending, mask, overrun flag, index.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them update from the
    // same pre-edge values; a blocking = would leak new values into later
    // statements of this block and change the pipeline timing.
    if (rst) begin
      irq_s   <= irq_in;
      pending <= '0;
      mask    <= '1;
      ovf     <= 1'b0;
      cur_idx <= '0;
    end else begin
      irq_s   <= irq_in;
      // A new event on the line being acknowledged wins over the clear.
      pending <= (pending & ~clr_vec) | evt;
      if (mask_we) mask <= mask_wdata;
      // Sticky overrun; a new overrun wins over a same-cycle clear.
      ovf     <= ovf_set | (ovf & ~ovf_clr);
      if (ack_take) cur_idx <= idx_in;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake next-state and state-decoded outputs.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; a missing
    // assignment on some branch would infer a latch.
    state_nxt = state;
    irq_req   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) state_nxt = REQ;
      end
      REQ: begin
        irq_req = 1'b1;
        if (ack_take)     state_nxt = SERVICE;
        else if (~|pend)  state_nxt = IDLE;
      end
      SERVICE: begin
        busy = 1'b1;
        if (irq_eoi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl. Works in both capture modes:
// stimulus uses single-cycle request pulses (identical in edge and level
// mode), and the few mode-dependent expectations are selected by EDGE.
module tb_irq_pending_ctrl;

`ifdef IRQ_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] pend;
  logic [2:0] idx_in;
  logic       irq_req;
  logic       irq_ack;
  logic       irq_eoi;
  logic [2:0] cur_idx;
  logic       busy;
  logic       ovf;
  logic       ovf_clr;

  int errors = 0;
  int checks = 0;

  irq_pending_ctrl #(.N(8), .IW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pend       (pend),
    .idx_in     (idx_in),
    .irq_req    (irq_req),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .cur_idx    (cur_idx),
    .busy       (busy),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  // Downstream 8:3 priority encoder model, bit 7 highest.
  always_comb begin
    idx_in = 3'd0;
    for (int i = 0; i < 8; i++)
      if (pend[i]) idx_in = 3'(i);
  end

  typedef struct {
    logic [7:0] irq;
    logic       mwe;
    logic [7:0] mwd;
    logic       ack;
    logic       eoi;
    logic [7:0] exp_pend;
    logic       exp_req;
    logic       exp_busy;
    logic [2:0] exp_cur;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [7:0] irq, input logic mwe,
                              input logic [7:0] mwd, input logic ack,
                              input logic eoi, input logic [7:0] ep,
                              input logic er, input logic eb,
                              input logic [2:0] ec);
    vec_t v;
    v.irq = irq; v.mwe = mwe; v.mwd = mwd; v.ack = ack; v.eoi = eoi;
    v.exp_pend = ep; v.exp_req = er; v.exp_busy = eb; v.exp_cur = ec;
    return v;
  endfunction

  task automatic check(input string name, input int step,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%02h expected 0x%02h", name, step, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] irq, input logic ack,
                       input logic eoi, input logic clr);
    irq_in = irq; irq_ack = ack; irq_eoi = eoi; ovf_clr = clr;
    mask_we = 1'b0; mask_wdata = 8'h00;
    tick();
  endtask

  task automatic check_all(input int step, input logic [7:0] ep,
                           input logic er, input logic eb,
                           input logic [2:0] ec, input logic eo);
    check("pend",    step, pend,            ep);
    check("irq_req", step, {7'd0, irq_req}, {7'd0, er});
    check("busy",    step, {7'd0, busy},    {7'd0, eb});
    check("cur_idx", step, {5'd0, cur_idx}, {5'd0, ec});
    check("ovf",     step, {7'd0, ovf},     {7'd0, eo});
  endtask

  initial begin
    // irq, mwe, mwd, ack, eoi | pend, req, busy, cur
    vecs[0]  = mk(8'h10, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3'd0); // sampled only
    vecs[1]  = mk(8'h00, 0, 8'h00, 0, 0, 8'h10, 0, 0, 3'd0); // pending set
    vecs[2]  = mk(8'h00, 0, 8'h00, 0, 0, 8'h10, 1, 0, 3'd0); // request
    vecs[3]  = mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 3'd4); // ack line 4
    vecs[4]  = mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 3'd4); // eoi
    vecs[5]  = mk(8'hC0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3'd4); // two lines
    vecs[6]  = mk(8'h00, 0, 8'h00, 0, 0, 8'hC0, 0, 0, 3'd4);
    vecs[7]  = mk(8'h00, 0, 8'h00, 0, 0, 8'hC0, 1, 0, 3'd4);
    vecs[8]  = mk(8'h00, 0, 8'h00, 1, 0, 8'h40, 0, 1, 3'd7); // ack 7 first
    vecs[9]  = mk(8'h00, 0, 8'h00, 0, 1, 8'h40, 0, 0, 3'd7); // eoi -> IDLE
    vecs[10] = mk(8'h00, 0, 8'h00, 0, 0, 8'h40, 1, 0, 3'd7); // req again
    vecs[11] = mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 3'd6); // ack 6
    vecs[12] = mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 3'd6);
    vecs[13] = mk(8'h04, 1, 8'hFB, 0, 0, 8'h00, 0, 0, 3'd6); // mask bit 2
    vecs[14] = mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3'd6); // latched, hidden
    vecs[15] = mk(8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3'd6);
    vecs[16] = mk(8'h00, 1, 8'hFF, 0, 0, 8'h04, 0, 0, 3'd6); // unmask
    vecs[17] = mk(8'h00, 0, 8'h00, 0, 0, 8'h04, 1, 0, 3'd6);
    vecs[18] = mk(8'h00, 1, 8'hFB, 0, 0, 8'h00, 1, 0, 3'd6); // mask in REQ
    vecs[19] = mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 3'd6); // ack w/ pend=0
    vecs[20] = mk(8'h00, 1, 8'hFF, 0, 0, 8'h04, 0, 0, 3'd6);
    vecs[21] = mk(8'h00, 0, 8'h00, 1, 0, 8'h04, 1, 0, 3'd6); // stray ack IDLE
    vecs[22] = mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 3'd2); // ack 2
    vecs[23] = mk(8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 3'd2); // stray ack SERVICE
    vecs[24] = mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 3'd2);
    vecs[25] = mk(8'h00, 0, 8'h00, 0, 1, 8'h00, 0, 0, 3'd2); // stray eoi IDLE

    // Reset with line 4 held high.
    rst = 1'b1; irq_in = 8'h10; mask_we = 1'b0; mask_wdata = 8'h00;
    irq_ack = 1'b0; irq_eoi = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    check_all(100, 8'h00, 0, 0, 3'd0, 0);
    rst = 1'b0;
    tick(); tick();
    // Edge mode: no event from a line held through reset. Level mode: the
    // high level is an event every cycle.
    check("held_pend", 101, pend,            EDGE ? 8'h00 : 8'h10);
    check("held_req",  102, {7'd0, irq_req}, EDGE ? 8'h00 : 8'h01);

    // Clean restart for the vector table.
    rst = 1'b1; irq_in = 8'h00;
    tick(); tick();
    rst = 1'b0;
    check_all(103, 8'h00, 0, 0, 3'd0, 0);

    for (int i = 0; i < NV; i++) begin
      irq_in = vecs[i].irq; mask_we = vecs[i].mwe; mask_wdata = vecs[i].mwd;
      irq_ack = vecs[i].ack; irq_eoi = vecs[i].eoi; ovf_clr = 1'b0;
      tick();
      check_all(i, vecs[i].exp_pend, vecs[i].exp_req, vecs[i].exp_busy,
                vecs[i].exp_cur, 1'b0);
    end

    // Overrun: second event on line 4 while it is still pending.
    drive(8'h10, 0, 0, 0);
    drive(8'h00, 0, 0, 0);
    check_all(200, 8'h10, 0, 0, 3'd2, 0);
    drive(8'h10, 0, 0, 0);
    drive(8'h00, 0, 0, 0);
    check_all(201, 8'h10, 1, 0, 3'd2, EDGE);
    drive(8'h00, 0, 0, 0);
    check("ovf_sticky", 202, {7'd0, ovf}, {7'd0, EDGE});
    drive(8'h00, 0, 0, 1);
    check("ovf_clr", 203, {7'd0, ovf}, 8'h00);

    // Event on line 4 in the ack cycle, together with ovf_clr: the set wins
    // for both the pending bit and the overrun flag.
    drive(8'h10, 0, 0, 0);
    drive(8'h00, 1, 0, 1);
    check_all(204, 8'h10, 0, 1, 3'd4, EDGE);
    drive(8'h00, 0, 1, 0);
    check_all(205, 8'h10, 0, 0, 3'd4, EDGE);
    drive(8'h00, 0, 0, 0);
    check_all(206, 8'h10, 1, 0, 3'd4, EDGE);
    drive(8'h00, 1, 0, 0);
    drive(8'h00, 0, 1, 0);
    check_all(207, 8'h00, 0, 0, 3'd4, EDGE);

    // Put line 6 in service, leave line 0 pending, then reset mid-service.
    drive(8'h40, 0, 0, 0);
    drive(8'h00, 0, 0, 0);
    drive(8'h00, 0, 0, 0);
    drive(8'h00, 1, 0, 0);
    check_all(208, 8'h00, 0, 1, 3'd6, EDGE);
    drive(8'h01, 0, 0, 0);
    drive(8'h00, 0, 0, 0);
    check_all(209, 8'h01, 0, 1, 3'd6, EDGE);
    rst = 1'b1;
    drive(8'h00, 0, 0, 0);
    check_all(210, 8'h00, 0, 0, 3'd0, 0);
    rst = 1'b0;
    drive(8'h00, 0, 0, 0);
    drive(8'h00, 0, 0, 0);
    check_all(211, 8'h00, 0, 0, 3'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

- Captures eight interrupt request lines into a pending register and applies a per-line enable mask.
- Presents the masked pending vector to the downstream 8:3 priority encoder, which drives `idx_in`.
- Runs a request/acknowledge/end-of-interrupt handshake with the servicing logic, tracks the line in service and flags overruns.

## Interface

Parameters:
- `N`, 8, number of request lines; equals the encoder input width.
- `IW`, 3, index width; equals clog2(N).

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `irq_in`  input  8  raw request lines, synchronous to `clk`.
- `mask_we`  input  1  write strobe for the mask register.
- `mask_wdata`  input  8  new mask value; 1 = line enabled.
- `pend`  output  8  pending & mask; drives the encoder `a` input.
- `idx_in`  input  3  encoder output `y`; the highest-priority pending line, bit 7 highest.
- `irq_req`  output  1  interrupt request to the servicing logic.
- `irq_ack`  input  1  acknowledge; valid only while `irq_req` = 1.
- `irq_eoi`  input  1  end-of-interrupt; valid only while `busy` = 1.
- `cur_idx`  output  3  line index in service.
- `busy`  output  1  a line is in service.
- `ovf`  output  1  sticky overrun flag.
- `ovf_clr`  input  1  clears `ovf`.

## Operation

Capture:
- A line event sets `pending[i]`. The event is a rising edge or a level; see Configuration.
- Masked lines still latch into `pending`. They are hidden from `pend` only.
- Overrun: an event on a line whose `pending` bit is already 1 sets `ovf`.
- If `ovf_clr` and a new overrun occur in the same cycle, the set wins.

Mask:
- A `mask_we` write takes effect on the next clock edge.
- `pend` is combinational from the `pending` and `mask` registers.

FSM states: IDLE, REQ, SERVICE.
- IDLE: go to REQ when `pend` != 0.
- REQ: `irq_req` = 1.
  - On `irq_ack` with `pend[idx_in]` = 1: `cur_idx` <= `idx_in`, clear `pending[idx_in]`, `busy` <= 1, go to SERVICE.
  - If `pend` becomes 0 (mask write) before the ack, go to IDLE and drop `irq_req`.
  - An ack while `pend` = 0 is ignored.
- SERVICE: `busy` = 1, `irq_req` = 0.
  - On `irq_eoi`: `busy` <= 0, go to IDLE.
  - New events keep latching; they are not nested.

Simultaneous events and stray strobes:
- A new event on line i in the same cycle that the ack clears `pending[i]`: set wins, and the bit stays pending.
- `irq_ack` outside REQ and `irq_eoi` outside SERVICE are ignored.

Reset values:
- `pending` = 0, `mask` = 8'hFF, `ovf` = 0.
- State = IDLE, `irq_req` = 0, `busy` = 0, `cur_idx` = 0.
- The edge history register loads `irq_in` during reset, so lines held high through reset raise no event.
- Reset mid-handshake aborts service immediately; all state returns to reset values on the next edge.

## Timing

- Event sampled at edge n: `pending`/`pend` visible after edge n+1.
- `irq_req` = 1 after edge n+2 when in IDLE.
- `irq_ack` sampled at edge k: the `pend` bit clears and `busy` = 1 after edge k. `irq_req` = 0 after edge k.
- `irq_eoi` at edge m: IDLE after edge m. If `pend` != 0, `irq_req` reasserts after edge m+1.
- Minimum event-to-event handshake period: 3 cycles.
- `idx_in` is combinational from `pend` through the encoder. It must settle within the same cycle; no internal register stage.

## Configuration

`IRQ_EDGE_DETECT_EN`:
- Defined: a line event is a 0→1 transition of `irq_in[i]` against the previous-cycle sample. Overrun detection is active.
- Undefined: a line event is `irq_in[i]` = 1 in any cycle (level mode). `pending[i]` re-sets every cycle the line is high, including right after an ack. `ovf` is tied to 0.

## Test plan

- Reset with `irq_in` = 8'h10 held → after release: `pend` = 0, `irq_req` = 0, `mask` = 8'hFF, no event.
- `irq_in` 0→8'h10 → `pend` = 8'h10 two edges later, `irq_req` = 1. Ack with `idx_in` = 4 → `cur_idx` = 4, `busy` = 1, `pend` = 0. EOI → `busy` = 0.
- Edges on 8'h80 and 8'h40 in the same cycle → ack `idx_in` = 7, `pend` = 8'h40. EOI → `irq_req` reasserts → ack `idx_in` = 6.
- `mask_wdata` = 8'hFB with an event on bit 2 → `pend` = 0, no `irq_req`. Write 8'hFF → `pend` = 8'h04, `irq_req` = 1.
- Second edge on bit 4 while `pending[4]` = 1 → `ovf` = 1. Sticky until `ovf_clr`. An edge on bit 4 in the ack cycle leaves `pend` = 8'h10.
- `rst` asserted in SERVICE with `cur_idx` = 6 → next cycle all outputs at reset values.
